// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler and the RX command decoder.
// Header byte is {tag, requester id}; the id field width is fixed at 3 bits.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2
    } state_t;

    localparam int         ID_W        = 3;
    localparam logic [4:0] HDR_TAG_DEF = 5'h14;

    function automatic logic [7:0] hdr_byte(input logic [4:0] tag, input logic [ID_W-1:0] id);
        return {tag, id};
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first set request searching ptr, ptr+1, ... mod NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the grant.
module uart_tx_scheduler_rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    always_comb begin
        int idx;
        gnt = '0;
        id  = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                id       = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler of NUM_REQ byte packets onto one UART TX byte channel.
// Latency: 1 idle cycle per grant (+1 header byte); payload passes through combinationally.
// Backpressure: tx_ready is forwarded to the granted requester's req_ready; others see 0.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter int         HEADER_EN = 1,
    parameter logic [4:0] HDR_TAG   = HDR_TAG_DEF,
    parameter int         MAX_LEN   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 len_err
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    state_t               state;
    logic [ID_W-1:0]      rr_ptr;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [CNT_W-1:0]     byte_cnt;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [ID_W-1:0]      arb_id;
    logic                 arb_any;

    logic                 cur_valid;
    logic                 cur_last;
    logic [7:0]           cur_data;
    logic                 pay_xfer;
    logic [ID_W-1:0]      next_ptr;

    uart_tx_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .id  (arb_id),
        .any (arb_any)
    );

    // One-hot and-or mux keeps the select free of out-of-range indexing.
    always_comb begin
        cur_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) cur_data = cur_data | req_data[8*i +: 8];
        end
    end

    assign cur_valid = |(req_valid & grant_oh);
    assign cur_last  = |(req_last & grant_oh);
    assign pay_xfer  = (state == S_PAY) && cur_valid && tx_ready;
    assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            grant_oh <= '0;
            byte_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            len_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        grant_oh <= arb_gnt;
                        grant_id <= arb_id;
                        byte_cnt <= '0;
                        state    <= (HEADER_EN != 0) ? S_HDR : S_PAY;
                    end
                end
                S_HDR: begin
                    if (tx_ready) begin
                        state    <= S_PAY;
                        byte_cnt <= '0;
                    end
                end
                S_PAY: begin
                    if (pay_xfer) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (cur_last) begin
                            state  <= S_IDLE;
                            rr_ptr <= next_ptr;
                        end else if (byte_cnt == CNT_W'(MAX_LEN - 1)) begin
                            // Force-terminate; the rest re-arbitrates as a fresh packet.
                            state   <= S_IDLE;
                            rr_ptr  <= next_ptr;
                            len_err <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        case (state)
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte(HDR_TAG, grant_id);
            end
            S_PAY: begin
                tx_valid  = cur_valid;
                tx_data   = cur_data;
                req_ready = tx_ready ? grant_oh : '0;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: one instance with headers, one without, both MAX_LEN=4,
// fed identical requester traffic; a scoreboard holds the expected TX byte stream of each.
module tb_uart_tx_scheduler;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_valid [2];
    logic [8*N-1:0]   req_data  [2];
    logic [N-1:0]     req_last  [2];
    logic [N-1:0]     req_ready [2];
    logic             tx_valid  [2];
    logic [7:0]       tx_data   [2];
    logic             tx_ready  [2];
    logic             busy      [2];
    logic [2:0]       grant_id  [2];
    logic             len_err   [2];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(N), .HEADER_EN(1), .HDR_TAG(5'h14), .MAX_LEN(4)) u_hdr (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_data(req_data[0]), .req_last(req_last[0]),
        .req_ready(req_ready[0]), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
        .tx_ready(tx_ready[0]), .busy(busy[0]), .grant_id(grant_id[0]), .len_err(len_err[0])
    );

    uart_tx_scheduler #(.NUM_REQ(N), .HEADER_EN(0), .HDR_TAG(5'h14), .MAX_LEN(4)) u_nohdr (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_data(req_data[1]), .req_last(req_last[1]),
        .req_ready(req_ready[1]), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
        .tx_ready(tx_ready[1]), .busy(busy[1]), .grant_id(grant_id[1]), .len_err(len_err[1])
    );

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  rq  [2][N][$];   // requester byte queues {last, data}
    logic [10:0] exq [2][$];      // expected TX stream {grant id, byte}
    bit          pop      [2][N];
    bit          busy_chk [2];
    bit          prev_stall [2];
    logic [7:0]  prev_data  [2];
    int          lenerr_cnt [2];
    int          xfer0 = 0;
    int          cyc = 0;
    bit          bp_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                if (rq[d][i].size() > 0) begin
                    req_valid[d][i]       = 1'b1;
                    req_data[d][8*i +: 8] = rq[d][i][0][7:0];
                    req_last[d][i]        = rq[d][i][0][8];
                end else begin
                    req_valid[d][i]       = 1'b0;
                    req_data[d][8*i +: 8] = 8'h00;
                    req_last[d][i]        = 1'b0;
                end
            end
            tx_ready[d] = bp_mode ? ((cyc % 2) == 0) : 1'b1;
        end
    endtask

    task automatic sample();
        logic [10:0] e;
        for (int d = 0; d < 2; d++) begin
            if (busy_chk[d]) begin
                check("busy_after_last", busy[d], 0);
                busy_chk[d] = 1'b0;
            end
            if (prev_stall[d]) begin
                check("stall_valid", tx_valid[d], 1);
                check("stall_data", tx_data[d], prev_data[d]);
            end
            check("rdy_follows_tx", req_ready[d] & ~{N{tx_ready[d]}}, 0);
            check("rdy_onehot", $countones(req_ready[d]) <= 1, 1);
            if (len_err[d]) begin
                lenerr_cnt[d]++;
                check("len_err_idle", busy[d], 0);
            end
            if (tx_valid[d] && tx_ready[d]) begin
                if (d == 0) xfer0++;
                if (exq[d].size() == 0) begin
                    check("tx_unexpected", {24'h0, tx_data[d]}, 32'hffff_ffff);
                end else begin
                    e = exq[d].pop_front();
                    check("tx_data", tx_data[d], e[7:0]);
                    check("grant_id", grant_id[d], e[10:8]);
                end
            end
            prev_stall[d] = tx_valid[d] && !tx_ready[d];
            prev_data[d]  = tx_data[d];
            for (int i = 0; i < N; i++) begin
                if (req_valid[d][i] && req_ready[d][i]) begin
                    pop[d][i] = 1'b1;
                    if (req_last[d][i]) busy_chk[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++)
                if (pop[d][i]) begin
                    void'(rq[d][i].pop_front());
                    pop[d][i] = 1'b0;
                end
        drive();
    endtask

    task automatic load(input int id, input logic [7:0] data, input bit last);
        for (int d = 0; d < 2; d++) rq[d][id].push_back({last, data});
    endtask

    task automatic exp_hdr(input int id);
        exq[0].push_back({3'(id), 8'hA0 | 8'(id)});
    endtask

    task automatic exp_byte(input int id, input logic [7:0] data);
        for (int d = 0; d < 2; d++) exq[d].push_back({3'(id), data});
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        drive();
        while ((exq[0].size() != 0 || exq[1].size() != 0) && n < 200) begin
            step();
            n++;
        end
        check({tag, "_drained"}, exq[0].size() + exq[1].size(), 0);
        step();
        step();
        check({tag, "_idle_hdr"}, busy[0], 0);
        check({tag, "_idle_nohdr"}, busy[1], 0);
    endtask

    task automatic flush();
        for (int d = 0; d < 2; d++) begin
            exq[d].delete();
            busy_chk[d]   = 1'b0;
            prev_stall[d] = 1'b0;
            for (int i = 0; i < N; i++) begin
                rq[d][i].delete();
                pop[d][i] = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_tx_valid"}, tx_valid[d], 0);
            check({tag, "_tx_data"}, tx_data[d], 0);
            check({tag, "_req_ready"}, req_ready[d], 0);
            check({tag, "_busy"}, busy[d], 0);
            check({tag, "_grant_id"}, grant_id[d], 0);
            check({tag, "_len_err"}, len_err[d], 0);
        end
    endtask

    initial begin
        int start;
        int n;
        reset_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = '1;
            req_data[d]  = '0;
            req_last[d]  = '0;
            tx_ready[d]  = 1'b1;
            lenerr_cnt[d] = 0;
        end
        flush();
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single packet from requester 0.
        load(0, 8'h11, 0); load(0, 8'h22, 1);
        exp_hdr(0); exp_byte(0, 8'h11); exp_byte(0, 8'h22);
        wait_done("single");

        // rr_ptr now 1: requester 1 wins over 0, leaving the pointer at 1.
        load(0, 8'h30, 1); load(1, 8'h31, 1);
        exp_hdr(1); exp_byte(1, 8'h31); exp_hdr(0); exp_byte(0, 8'h30);
        wait_done("ptr1");

        // Requester 3 alone wraps the pointer back to 0.
        load(3, 8'h33, 1);
        exp_hdr(3); exp_byte(3, 8'h33);
        wait_done("wrap");

        for (int i = 0; i < N; i++) load(i, 8'h40 + 8'(i), 1);
        for (int i = 0; i < N; i++) begin exp_hdr(i); exp_byte(i, 8'h40 + 8'(i)); end
        wait_done("rr_from0");

        load(1, 8'h50, 1);
        exp_hdr(1); exp_byte(1, 8'h50);
        wait_done("to_ptr2");

        for (int i = 0; i < N; i++) load(i, 8'h60 + 8'(i), 1);
        for (int k = 0; k < N; k++) begin exp_hdr((k + 2) % N); exp_byte((k + 2) % N, 8'h60 + 8'((k + 2) % N)); end
        wait_done("rr_from2");

        // Backpressure: tx_ready alternates every cycle.
        bp_mode = 1'b1;
        load(2, 8'h71, 0); load(2, 8'h72, 0); load(2, 8'h73, 1);
        exp_hdr(2); exp_byte(2, 8'h71); exp_byte(2, 8'h72); exp_byte(2, 8'h73);
        wait_done("backpressure");
        bp_mode = 1'b0;

        // Over-length packet: cut after 4 bytes, remainder re-granted as a new packet.
        lenerr_cnt[0] = 0;
        lenerr_cnt[1] = 0;
        for (int b = 0; b < 6; b++) load(1, 8'h80 + 8'(b), b == 5);
        exp_hdr(1);
        for (int b = 0; b < 4; b++) exp_byte(1, 8'h80 + 8'(b));
        exp_hdr(1);
        for (int b = 4; b < 6; b++) exp_byte(1, 8'h80 + 8'(b));
        wait_done("maxlen");
        check("len_err_count_hdr", lenerr_cnt[0], 1);
        check("len_err_count_nohdr", lenerr_cnt[1], 1);

        // Reset mid-packet once the header instance has sent header + 2 bytes.
        for (int b = 0; b < 4; b++) load(2, 8'h90 + 8'(b), b == 3);
        exp_hdr(2);
        exq[0].push_back({3'd2, 8'h90});
        exq[0].push_back({3'd2, 8'h91});
        for (int b = 0; b < 4; b++) exq[1].push_back({3'd2, 8'h90 + 8'(b)});
        drive();
        start = xfer0;
        n = 0;
        while (xfer0 < start + 3 && n < 50) begin
            step();
            n++;
        end
        check("midrst_setup", xfer0 - start, 3);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        flush();
        drive();
        @(negedge clk);
        check_reset_outputs("midrst_held");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Pointer must be back at 0: requester 1 beats requester 3.
        load(3, 8'hA3, 1); load(1, 8'hA1, 1);
        exp_hdr(1); exp_byte(1, 8'hA1); exp_hdr(3); exp_byte(3, 8'hA3);
        wait_done("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
